// File: rtl/bram_uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bram_uart_tx_pkg                                           |
// | Description : Shared types and constants for the BRAM-to-UART            |
// |               transmitter: FSM state encoding, frame geometry and the    |
// |               clocks-per-bit calculation.                                |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package bram_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Clock cycles per UART bit; integer division truncates.
  function automatic int unsigned calc_cpb(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bram_uart_tx_if                                            |
// | Description : Bundles the run-control, BRAM read and UART line signals.  |
// |   start    : request to begin a run                                      |
// |   en       : transmit enable                                             |
// |   ram_addr : BRAM word address (from transmitter)                        |
// |   ram_dout : BRAM read data, one cycle after ram_addr                    |
// |   tx       : UART serial line, idle high                                 |
// |   busy     : run in progress                                             |
// |   done     : one-cycle completion pulse                                  |
// | Modports    : master = transmitter, slave = host/BRAM side               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface bram_uart_tx_if;
  logic        start;
  logic        en;
  logic [15:0] ram_addr;
  logic [31:0] ram_dout;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (input start, en, ram_dout, output ram_addr, tx, busy, done);
  modport slave  (output start, en, ram_dout, input ram_addr, tx, busy, done);
endinterface
`default_nettype wire

// File: rtl/bram_uart_tx_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bram_uart_tx_baud_tick                                     |
// | Description : Bit-period counter. Counts 0..CPB-1, pulses tick on the    |
// |               last count and wraps. restart holds the count at zero so   |
// |               each frame starts on a fresh bit period.                   |
// | Ports       : clk, rst (async, active high), restart in, tick out        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bram_uart_tx_baud_tick #(
  parameter int unsigned CPB = 135
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned                c_cnt_w = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [c_cnt_w-1:0]         c_last  = c_cnt_w'(CPB - 1);

  logic [c_cnt_w-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bram_uart_tx                                               |
// | Description : Streams `elements` bytes from a 32-bit BRAM out of an 8N1  |
// |               UART. Words are read in address order, bytes LSB first.    |
// | Ports       : clk, rst (async, active high)                              |
// |               bus.master : start, en, ram_dout in;                       |
// |                            ram_addr, tx, busy, done out                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bram_uart_tx
  import bram_uart_tx_pkg::*;
#(
  parameter int unsigned freq_Sys = 125000000,
  parameter int unsigned baudRate = 921600,
  parameter logic [16:0] elements = 17'd65536
) (
  input  logic           clk,
  input  logic           rst,
  bram_uart_tx_if.master bus
);

  localparam int unsigned c_cpb       = calc_cpb(freq_Sys, baudRate);
  localparam logic [16:0] c_last_byte = elements - 17'd1;

  state_t      r_state;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_addr;
  logic [31:0] r_word;
  logic [2:0]  r_bit_idx;
  logic [1:0]  r_byte_idx;
  logic [16:0] r_byte_cnt;  // 17 bits so a full 65536-byte run never wraps

  logic w_tick;
  logic w_restart;

  // Hold the bit timer at zero whenever no frame is on the line, so the
  // first start bit after a fetch gets a full bit period. Back-to-back
  // frames rely on the timer's own wrap instead.
  assign w_restart = (r_state == IDLE) || (r_state == FETCH) ||
                     (r_state == LATCH) || (r_state == DONE);

  bram_uart_tx_baud_tick #(.CPB(c_cpb)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ram_addr = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_word     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_addr <= '0;
          if (bus.start && bus.en) begin
            r_busy     <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= FETCH;
          end
        end
        // ram_addr is stable here; BRAM data appears during LATCH.
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_word     <= bus.ram_dout;
          r_byte_idx <= '0;
          r_tx       <= 1'b0;
          r_state    <= START;
        end
        START: if (w_tick) begin
          r_tx      <= r_word[0];
          r_word    <= {1'b0, r_word[31:1]};
          r_bit_idx <= '0;
          r_state   <= DATA;
        end
        // The word shifts right one bit per data bit, so after eight bits
        // the next byte already sits in bits [7:0].
        DATA: if (w_tick) begin
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_tx      <= r_word[0];
            r_word    <= {1'b0, r_word[31:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        STOP: if (w_tick) begin
          r_byte_cnt <= r_byte_cnt + 17'd1;
          if (!bus.en) begin
            // Enable dropped: the frame just finished, abandon the run quietly.
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_state <= IDLE;
          end else if (r_byte_idx != 2'(BYTES_PER_WORD - 1)) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_tx       <= 1'b0;
            r_state    <= START;
          end else if (r_byte_cnt == c_last_byte) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + 16'd1;
            r_state <= FETCH;
          end
        end
        DONE: begin
          r_addr  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bram_uart_tx                                            |
// | Description : Self-checking bench. A small instance (CPB=16, 8 bytes) is |
// |               compared every cycle against an expected line waveform     |
// |               built from the 8N1 framing rules; a large instance         |
// |               (CPB=2, 65536 bytes) checks frame count and final address. |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bram_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic rst_big = 1'b0;

  always #5 clk = ~clk;

  bram_uart_tx_if sb();
  bram_uart_tx_if bb();

  bram_uart_tx #(.freq_Sys(16), .baudRate(1), .elements(17'd8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (sb.master)
  );

  bram_uart_tx #(.freq_Sys(2), .baudRate(1), .elements(17'd65536)) u_big (
    .clk (clk),
    .rst (rst_big),
    .bus (bb.master)
  );

  // BRAM models, one cycle read latency.
  logic [31:0] mem [0:1] = '{32'h44332211, 32'h88776655};
  always @(posedge clk) sb.ram_dout <= (sb.ram_addr < 16'd2) ? mem[sb.ram_addr[0]] : 32'h0;
  always @(posedge clk) bb.ram_dout <= {bb.ram_addr, ~bb.ram_addr};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- expected-waveform model ----------------
  typedef struct packed {
    logic        tx;
    logic        busy;
    logic        done;
    logic        ca;     // compare ram_addr on this sample
    logic [15:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic        act_tx[$];
  logic        act_done[$];
  logic [15:0] act_addr[$];
  logic [7:0]  got[$];
  bit          chk_on = 1'b0;

  logic [7:0] exp_bytes [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  task automatic push_n(input int n, input logic tx, input logic busy, input logic done,
                        input logic ca, input logic [15:0] addr);
    for (int i = 0; i < n; i++) exp_q.push_back('{tx, busy, done, ca, addr});
  endtask

  // Line waveform for a run: two setup cycles, then per byte 1 start, 8 data
  // LSB first and 1 stop bit of CPB cycles each, two idle cycles before every
  // new word, and a done cycle if the run completes.
  task automatic build_run(input int nbytes, input bit full);
    logic [15:0] w;
    logic [7:0]  v;
    push_n(2, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0);
    for (int b = 0; b < nbytes; b++) begin
      w = 16'(b / 4);
      v = 8'(mem[b / 4] >> (8 * (b % 4)));
      if (b % 4 == 0 && b != 0) push_n(2, 1'b1, 1'b1, 1'b0, 1'b1, w);
      push_n(CPB, 1'b0, 1'b1, 1'b0, 1'b1, w);
      for (int k = 0; k < 8; k++) push_n(CPB, v[k], 1'b1, 1'b0, 1'b1, w);
      push_n(CPB, 1'b1, 1'b1, 1'b0, 1'b1, w);
    end
    if (full) push_n(1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  // Per-cycle compare; an empty model queue means the line must be idle.
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      if (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
        act_tx.push_back(sb.tx);
        act_done.push_back(sb.done);
        act_addr.push_back(sb.ram_addr);
      end else begin
        cur_e = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
      end
      chk("tx", 32'(sb.tx), 32'(cur_e.tx));
      chk("busy", 32'(sb.busy), 32'(cur_e.busy));
      chk("done", 32'(sb.done), 32'(cur_e.done));
      if (cur_e.ca) chk("ram_addr", 32'(sb.ram_addr), 32'(cur_e.addr));
    end
  end

  task automatic launch(input int nbytes, input bit full);
    @(negedge clk);
    sb.en    = 1'b1;
    sb.start = 1'b1;
    @(posedge clk);
    #1;
    sb.start = 1'b0;
    act_tx.delete();
    act_done.delete();
    act_addr.delete();
    build_run(nbytes, full);
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk({name, " drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Plain UART receiver over the logged line: find a start bit, sample mid-bit.
  task automatic decode();
    int i;
    logic [7:0] v;
    got.delete();
    i = 0;
    while (i + FRAME <= act_tx.size()) begin
      if (act_tx[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) v[k] = act_tx[i + CPB * (k + 1) + CPB / 2];
        got.push_back(v);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_bytes(input string name, input int n);
    chk({name, " frames"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n && k < got.size(); k++) chk(name, 32'(got[k]), 32'(exp_bytes[k]));
  endtask

  function automatic int count_done();
    int c;
    c = 0;
    for (int k = 0; k < act_done.size(); k++) if (act_done[k]) c++;
    return c;
  endfunction

  function automatic int count_addr_changes();
    int c;
    c = 0;
    for (int k = 1; k < act_addr.size(); k++) if (act_addr[k] != act_addr[k-1]) c++;
    return c;
  endfunction

  // ---------------- large instance ----------------
  int          big_frames   = 0;
  int          big_dones    = 0;
  int          big_skip     = 0;
  logic [15:0] big_max_addr = 16'd0;
  logic [15:0] big_done_addr = 16'd0;

  initial begin
    bb.start = 1'b0;
    bb.en    = 1'b0;
    #1 rst_big = 1'b1;
    repeat (2) @(negedge clk);
    rst_big = 1'b0;
    @(negedge clk);
    bb.en    = 1'b1;
    bb.start = 1'b1;
    @(negedge clk);
    bb.start = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_big) begin
      if (bb.done) begin
        big_dones     <= big_dones + 1;
        big_done_addr <= bb.ram_addr;
      end
      if (bb.busy && bb.ram_addr > big_max_addr) big_max_addr <= bb.ram_addr;
      if (big_skip > 0) big_skip <= big_skip - 1;
      else if (bb.tx == 1'b0) begin
        big_frames <= big_frames + 1;
        big_skip   <= 19;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    sb.start = 1'b0;
    sb.en    = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset tx", 32'(sb.tx), 32'd1);
    chk("reset busy", 32'(sb.busy), 32'd0);
    chk("reset done", 32'(sb.done), 32'd0);
    chk("reset ram_addr", 32'(sb.ram_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Full run, with a start pulse during the transfer that must be ignored.
    launch(8, 1'b1);
    repeat (501) @(negedge clk);
    #1 sb.start = 1'b1;
    @(negedge clk);
    #1 sb.start = 1'b0;
    wait_drain("run1");
    decode();
    check_bytes("run1 byte", 8);
    chk("run1 first start bit", 32'(act_tx[2]), 32'd0);
    chk("run1 start bit end", 32'(act_tx[17]), 32'd0);
    chk("run1 bit0 of 11", 32'(act_tx[26]), 32'd1);
    chk("run1 bit1 of 11", 32'(act_tx[42]), 32'd0);
    chk("run1 gap cycle 1", 32'(act_tx[642]), 32'd1);
    chk("run1 gap cycle 2", 32'(act_tx[643]), 32'd1);
    chk("run1 start of 55", 32'(act_tx[644]), 32'd0);
    chk("run1 done position", 32'(act_done[1284]), 32'd1);
    chk("run1 done count", 32'(count_done()), 32'd1);
    chk("run1 addr changes", 32'(count_addr_changes()), 32'd1);
    repeat (20) @(negedge clk);

    // start with en low must not leave IDLE.
    @(negedge clk);
    sb.en    = 1'b0;
    sb.start = 1'b1;
    @(negedge clk);
    sb.start = 1'b0;
    repeat (50) @(negedge clk);
    chk("en0 start busy", 32'(sb.busy), 32'd0);

    // en dropped during bit 3 of byte 22: that frame completes, then abort.
    launch(2, 1'b0);
    repeat (235) @(negedge clk);
    #1 sb.en = 1'b0;
    wait_drain("endrop");
    repeat (200) @(negedge clk);
    decode();
    check_bytes("endrop byte", 2);
    chk("endrop done count", 32'(count_done()), 32'd0);
    sb.en = 1'b1;

    // Reset during the data bits of byte 33.
    launch(8, 1'b1);
    repeat (401) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset tx", 32'(sb.tx), 32'd1);
    chk("midreset busy", 32'(sb.busy), 32'd0);
    chk("midreset ram_addr", 32'(sb.ram_addr), 32'd0);
    chk("midreset done", 32'(sb.done), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // A fresh run after the reset starts from byte 11 again.
    launch(8, 1'b1);
    wait_drain("run2");
    decode();
    check_bytes("run2 byte", 8);
    chk("run2 done count", 32'(count_done()), 32'd1);

    // Large run: 65536 bytes, last address 16383, one done.
    for (int i = 0; i < 1500000 && big_dones == 0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("big done count", 32'(big_dones), 32'd1);
    chk("big frames", 32'(big_frames), 32'd65536);
    chk("big max ram_addr", 32'(big_max_addr), 32'd16383);
    chk("big ram_addr at done", 32'(big_done_addr), 32'd16383);
    chk("big idle busy", 32'(bb.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_uart_tx.md
BRAM_UART_TX -- requirements
Module: bram_uart_tx

Interface
REQ-001 Parameter freq_Sys, default 125000000, system clock frequency in Hz.
REQ-002 Parameter baudRate, default 921600, UART bit rate.
REQ-003 Parameter elements, default 17'd65536, number of bytes to transmit per run; a multiple of 4, at most 65536.
REQ-004 clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin a run; sampled on a clk edge.
REQ-007 en  input  1  transmit enable.
REQ-008 ram_addr  output  16  BRAM word address.
REQ-009 ram_dout  input  32  BRAM read data, valid 1 cycle after ram_addr.
REQ-010 tx  output  1  UART serial line; idle high.
REQ-011 busy  output  1  high from run acceptance until the final stop bit ends.
REQ-012 done  output  1  one-cycle pulse on run completion.

Function
REQ-013 Baud timing: CPB = freq_Sys/baudRate (integer division; 135 at defaults); every bit, including start and stop, lasts exactly CPB clk cycles, counted by an internal counter (no derived clock).
REQ-014 Frame format: 8N1; start bit 0, data bits LSB first, one stop bit 1.
REQ-015 Word order: word k sits at ram_addr k, for k = 0 .. elements/4-1.
REQ-016 Byte order within a word: bits [7:0] first, then [15:8], [23:16], [31:24].
REQ-017 States: IDLE, FETCH, LATCH, START, DATA, STOP, DONE.
REQ-018 IDLE: tx=1, busy=0, ram_addr=0.
  - start=1 and en=1 -> FETCH, busy=1 next cycle.
  - start with en=0 is ignored.
REQ-019 FETCH drives ram_addr and lasts 1 cycle -> LATCH.
REQ-020 LATCH captures ram_dout into a 32-bit shift word, sets byte index 0 -> START.
REQ-021 START holds tx=0 for CPB cycles -> DATA.
REQ-022 DATA shifts out 8 bits, each for CPB cycles -> STOP.
REQ-023 STOP holds tx=1 for CPB cycles, then:
  - byte index < 3: increment index, next byte -> START; no gap between frames.
  - byte index = 3 and more words remain: increment ram_addr -> FETCH; inter-word gap is exactly 2 cycles of tx=1.
  - byte index = 3 and last word: -> DONE.
REQ-024 DONE: done=1 for one cycle, busy=0 in the same cycle, ram_addr returns to 0 -> IDLE.
REQ-025 start asserted while busy=1 is ignored; no queuing.
REQ-026 en falling mid-run: the current frame completes through its stop bit, then the run aborts to IDLE with no done pulse; bytes already sent are not resent.
REQ-027 Counters: byte counter is 17 bits wide, so elements=65536 completes without wrap. Final ram_addr of a run is elements/4-1.
REQ-028 tx is driven from a register; no combinational path from any input to tx.

Reset
REQ-029 rst=1 forces immediately, independent of clk: state IDLE, tx=1, busy=0, done=0, ram_addr=0, all counters and the shift word 0.
REQ-030 Reset mid-frame truncates the frame; after release the block waits in IDLE for a new start.

Structure
REQ-031 A shared package holds:
  - the state enumeration;
  - the CPB computation;
  - the frame constants: 8 data bits, 4 bytes per word.
REQ-032 One sub-module, baud_tick:
  - counts to CPB-1;
  - pulses a tick and self-restarts;
  - clears on rst or on a restart input asserted at each frame start.

Verification (freq_Sys=16, baudRate=1, CPB=16, elements=8; BRAM model with 1-cycle latency)
REQ-033 Single run: word0=32'h44332211, word1=32'h88776655, start pulse -> tx bytes 11,22,33,44,55,66,77,88; each bit exactly 16 cycles; done pulses once; busy spans the whole run.
REQ-034 Inter-word gap: between the stop bit of byte 44 and the start bit of byte 55, tx=1 for exactly 2 cycles; ram_addr changes 0->1 exactly once.
REQ-035 en drop: deassert en during bit 3 of byte 22 -> the 22 frame completes; then busy=0, no done, tx=1, and no further start bits.
REQ-036 start ignored: start pulsed while busy and start with en=0 -> the byte sequence is unchanged, no extra run, no activity from IDLE.
REQ-037 Reset mid-frame: assert rst during the data bits of byte 33 -> tx=1, busy=0, ram_addr=0 before the next clk edge; a following start sends from byte 11.
REQ-038 Boundary: run with elements=65536 (scaled CPB=2) -> last ram_addr = 16383, exactly 65536 frames, a single done.
